systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_pkg.sv | 23 ++
 rtl/systolic_feeder_skew.sv | 33 +++
 rtl/systolic_feeder.sv | 110 +++++++++++
 tb/tb_systolic_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared systolic definitions: element width, feeder FSM state encoding and flush length.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package systolic_feeder_pkg;

    localparam int DW = `DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // Cycles of zero-fill needed to drain the deepest skew lane and the
    // full diagonal of the array behind it.
    function automatic int flush_len(input int tile_dim);
        return 2 * tile_dim;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew.sv
// One skew lane: DEPTH-stage enabled shift chain with synchronous clear.
module skew_lane #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (clr_i) begin
            sh_d = '0;
        end else if (en_i) begin
            sh_d[0] = d_i;
            for (int k = 1; k < DEPTH; k++) sh_d[k] = sh_q[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sh_q <= '0;
        else         sh_q <= sh_d;
    end

    assign q_o = sh_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews A columns / B rows into a TILE_DIM x TILE_DIM systolic array and drains it with zeros.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int TILE_DIM = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [0:TILE_DIM*DW-1] in_a,
    input  logic [0:TILE_DIM*DW-1] in_b,
    output logic                   sa_enb,
    output logic [0:TILE_DIM*DW-1] sa_in_row,
    output logic [0:TILE_DIM*DW-1] sa_in_col,
    output logic                   busy,
    output logic                   done
);

    localparam int FLUSH_N = flush_len(TILE_DIM);
    localparam int CW      = $clog2(FLUSH_N) + 1;

    feeder_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic          in_ready_q, busy_q, done_q;
    logic          shift_en, clr, accept;

    assign accept = (state_q == ST_STREAM) && in_valid;
    assign clr    = (state_q == ST_IDLE) && start;

    // The skew chains and the array advance together, so a missing slice
    // stalls the whole pipeline instead of injecting a bubble.
    always_comb begin
        shift_en = 1'b0;
        case (state_q)
            ST_STREAM: shift_en = in_valid;
            ST_FLUSH:  shift_en = 1'b1;
            default:   shift_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q    <= ST_STREAM;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
                ST_STREAM: if (accept && in_last) begin
                    state_q    <= ST_FLUSH;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                end
                ST_FLUSH: begin
                    if (cnt_q == CW'(FLUSH_N - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sa_enb   = shift_en;

    for (genvar i = 0; i < TILE_DIM; i++) begin : g_lane
        logic [DW-1:0] a_head, b_head;

        assign a_head = (state_q == ST_STREAM) ? in_a[i*DW +: DW] : '0;
        assign b_head = (state_q == ST_STREAM) ? in_b[i*DW +: DW] : '0;

        skew_lane #(.DEPTH(i + 1), .W(DW)) u_row (
            .clk_i  (clk),
            .rstn_i (rstn),
            .en_i   (shift_en),
            .clr_i  (clr),
            .d_i    (a_head),
            .q_o    (sa_in_row[i*DW +: DW])
        );

        skew_lane #(.DEPTH(i + 1), .W(DW)) u_col (
            .clk_i  (clk),
            .rstn_i (rstn),
            .en_i   (shift_en),
            .clr_i  (clr),
            .d_i    (b_head),
            .q_o    (sa_in_col[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder at TILE_DIM=4, 8-bit elements, with a downstream array model.
module tb_systolic_feeder;
    import systolic_feeder_pkg::*;

    localparam int T  = 4;
    localparam int VW = T * DW;

    logic          clk = 1'b0, rstn = 1'b0;
    logic          start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic          in_ready, sa_enb, busy, done;
    logic [0:VW-1] in_a = '0, in_b = '0, sa_in_row, sa_in_col;

    int n_vec = 0, n_bad = 0, done_cnt = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    systolic_feeder #(.TILE_DIM(T)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_a(in_a), .in_b(in_b), .sa_enb(sa_enb),
        .sa_in_row(sa_in_row), .sa_in_col(sa_in_col), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [0:VW-1] mk(input int s, input int off);
        logic [0:VW-1] v;
        for (int i = 0; i < T; i++) v[i*DW +: DW] = DW'(s * 16 + i + off);
        return v;
    endfunction

    function automatic logic [0:VW-1] onehot(input int k);
        logic [0:VW-1] v;
        v = '0;
        v[k*DW +: DW] = DW'(1);
        return v;
    endfunction

    // Scoreboard: each enabled edge pushes the lane heads it clocks in;
    // lane i at the array port then shows the head pushed i edges earlier.
    typedef struct { logic [0:VW-1] a; logic [0:VW-1] b; } head_t;
    head_t sb[$];

    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
        end else if (mon_on) begin
            logic [0:VW-1] er, ec;
            head_t h;
            er = '0; ec = '0;
            for (int i = 0; i < T; i++)
                if (sb.size() > i) begin
                    er[i*DW +: DW] = sb[sb.size()-1-i].a[i*DW +: DW];
                    ec[i*DW +: DW] = sb[sb.size()-1-i].b[i*DW +: DW];
                end
            chk("mon_row", sa_in_row, er);
            chk("mon_col", sa_in_col, ec);
            if (start && !busy) begin
                sb.delete();
            end else if (sa_enb) begin
                h.a = in_ready ? in_a : '0;
                h.b = in_ready ? in_b : '0;
                sb.push_back(h);
                if (sb.size() > T) void'(sb.pop_front());
            end
        end
    end

    always @(negedge clk) if (done) done_cnt++;

    // Output-stationary reference array fed from the skewed streams.
    int acc [T][T];
    int a_r [T][T];
    int b_r [T][T];

    always @(posedge clk or negedge rstn) begin
        if (!rstn || (start && !busy)) begin
            for (int r = 0; r < T; r++)
                for (int c = 0; c < T; c++) begin
                    acc[r][c] <= 0; a_r[r][c] <= 0; b_r[r][c] <= 0;
                end
        end else if (sa_enb) begin
            for (int r = 0; r < T; r++)
                for (int c = 0; c < T; c++) begin
                    int ai, bi;
                    ai = (c == 0) ? int'(sa_in_row[r*DW +: DW]) : a_r[r][c-1];
                    bi = (r == 0) ? int'(sa_in_col[c*DW +: DW]) : b_r[r-1][c];
                    a_r[r][c] <= ai;
                    b_r[r][c] <= bi;
                    acc[r][c] <= acc[r][c] + ai * bi;
                end
        end
    end

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = done;
            if (!seen) step();
        end
        chk(nm, 64'(seen), 64'd1);
        step();
    endtask

    typedef struct {
        logic        iv, il;
        logic [31:0] a, b;
        logic        enb, rdy, bsy, dn;
        logic [31:0] row, col;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [0:VW-1] held_row, held_col;
        int dc0;

        for (int k = 0; k < 11; k++) begin
            vt[k] = '{iv:0, il:0, a:0, b:0, enb:(k <= 8), rdy:(k == 0),
                      bsy:(k <= 9), dn:(k == 9), row:0, col:0};
        end
        vt[0].iv = 1; vt[0].il = 1; vt[0].a = 32'h01020304; vt[0].b = 32'h10203040;
        vt[1].row = 32'h01000000; vt[1].col = 32'h10000000;
        vt[2].row = 32'h00020000; vt[2].col = 32'h00200000;
        vt[3].row = 32'h00000300; vt[3].col = 32'h00003000;
        vt[4].row = 32'h00000004; vt[4].col = 32'h00000040;

        // reset state
        step(); step();
        chk("rst_ready", 64'(in_ready), 0);
        chk("rst_busy",  64'(busy), 0);
        chk("rst_done",  64'(done), 0);
        chk("rst_enb",   64'(sa_enb), 0);
        chk("rst_row",   64'(sa_in_row), 0);
        chk("rst_col",   64'(sa_in_col), 0);
        rstn = 1'b1; mon_on = 1'b1;
        step();

        // single-slice pass, cycle-by-cycle table
        pulse_start();
        for (int k = 0; k < 11; k++) begin
            in_valid = vt[k].iv; in_last = vt[k].il; in_a = vt[k].a; in_b = vt[k].b;
            @(negedge clk);
            chk($sformatf("t%0d_enb", k),  64'(sa_enb),    64'(vt[k].enb));
            chk($sformatf("t%0d_rdy", k),  64'(in_ready),  64'(vt[k].rdy));
            chk($sformatf("t%0d_busy", k), 64'(busy),      64'(vt[k].bsy));
            chk($sformatf("t%0d_done", k), 64'(done),      64'(vt[k].dn));
            chk($sformatf("t%0d_row", k),  64'(sa_in_row), 64'(vt[k].row));
            chk($sformatf("t%0d_col", k),  64'(sa_in_col), 64'(vt[k].col));
            step();
        end

        // four slices with a three-cycle stall after slice 2
        pulse_start();
        for (int s = 1; s <= 2; s++) begin
            in_valid = 1; in_a = mk(s, 1); in_b = mk(s, 8); step();
        end
        in_valid = 0; in_a = mk(9, 0); in_b = mk(9, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_enb", 64'(sa_enb), 0);
            if (c == 0) begin
                held_row = sa_in_row; held_col = sa_in_col;
            end else begin
                chk("stall_row", 64'(sa_in_row), 64'(held_row));
                chk("stall_col", 64'(sa_in_col), 64'(held_col));
            end
            step();
        end
        for (int s = 3; s <= 4; s++) begin
            in_valid = 1; in_last = (s == 4); in_a = mk(s, 1); in_b = mk(s, 8); step();
        end
        in_valid = 0; in_last = 0;
        wait_done("stall_done");

        // in_valid in IDLE ignored; start in STREAM ignored
        in_valid = 1; in_a = mk(5, 1); in_b = mk(5, 8);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("idle_ready", 64'(in_ready), 0);
            chk("idle_enb",   64'(sa_enb), 0);
            chk("idle_busy",  64'(busy), 0);
            step();
        end
        in_valid = 0;
        pulse_start();
        in_valid = 1; step();
        in_valid = 0; start = 1; step();
        start = 0;
        @(negedge clk);
        chk("strm_start_ready", 64'(in_ready), 1);
        chk("strm_start_busy",  64'(busy), 1);
        step();
        in_valid = 1; in_last = 1; in_a = mk(6, 1); in_b = mk(6, 8); step();
        in_valid = 0; in_last = 0;
        wait_done("ign_done");

        // reset in the middle of FLUSH with counter at 3
        pulse_start();
        in_valid = 1; in_last = 1; in_a = mk(7, 1); in_b = mk(7, 8); step();
        in_valid = 0; in_last = 0;
        step(); step(); step();
        dc0 = done_cnt;
        #1 rstn = 1'b0;
        #1;
        chk("mrst_enb",   64'(sa_enb), 0);
        chk("mrst_row",   64'(sa_in_row), 0);
        chk("mrst_col",   64'(sa_in_col), 0);
        chk("mrst_busy",  64'(busy), 0);
        chk("mrst_done",  64'(done), 0);
        chk("mrst_ready", 64'(in_ready), 0);
        step(); step();
        rstn = 1'b1;
        for (int c = 0; c < 12; c++) step();
        chk("mrst_no_done", 64'(done_cnt), 64'(dc0));
        @(negedge clk);
        chk("mrst_idle_busy", 64'(busy), 0);
        step();

        // identity x identity through the reference array
        pulse_start();
        for (int k = 0; k < T; k++) begin
            in_valid = 1; in_last = (k == T - 1); in_a = onehot(k); in_b = onehot(k); step();
        end
        in_valid = 0; in_last = 0;
        wait_done("id_done");
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++)
                chk($sformatf("id_acc_%0d_%0d", r, c), 64'(acc[r][c]), 64'(r == c));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
